hwpe_cfg_arbiter: RTL and testbench
===================================

HWPE_CFG_ARBITER -- requirements
Module: hwpe_cfg_arbiter

Interface
REQ-001: Parameter N_REQ, default 4, SHALL set the number of requesting cores sharing one HWPE programming port (range 2..16).
REQ-002: Parameter ADDR_WIDTH, default 32, SHALL set the address width.
REQ-003: Parameter DATA_WIDTH, default 32, SHALL set the data width; BE width SHALL be DATA_WIDTH/8.
REQ-004: Parameter TIMEOUT_CYCLES, default 255, SHALL set the response timeout (used only with HWPE_CFG_ARB_TIMEOUT_EN).
REQ-005: clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-006: rst_i  in  1  asynchronous, active-high reset.
REQ-007: req_i  in  N_REQ  per-core request.
REQ-008: add_i  in  N_REQ*ADDR_WIDTH  packed per-core address, core k at slice k.
REQ-009: wen_i  in  N_REQ  per-core write-enable-low (1 = read, 0 = write).
REQ-010: wdata_i  in  N_REQ*DATA_WIDTH  packed per-core write data.
REQ-011: be_i  in  N_REQ*DATA_WIDTH/8  packed per-core byte enables.
REQ-012: gnt_o  out  N_REQ  per-core grant, one-hot or zero.
REQ-013: r_valid_o  out  N_REQ  per-core response valid, one-hot or zero.
REQ-014: r_rdata_o  out  DATA_WIDTH  response data, shared by all cores.
REQ-015: r_opc_o  out  1  response error flag (1 = error), shared.
REQ-016: tgt_req_o / tgt_add_o / tgt_wen_o / tgt_wdata_o / tgt_be_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  request to the HWPE port.
REQ-017: tgt_gnt_i  in  1  target grant.
REQ-018: tgt_r_valid_i / tgt_r_rdata_i / tgt_r_opc_i  in  1/DATA_WIDTH/1  target response.

Function
REQ-019: FSM states SHALL be IDLE, ISSUE, WAIT_RESP and, with the macro, ERR_RESP.
REQ-020: At most one transaction SHALL be outstanding; no core SHALL be granted outside IDLE.
REQ-021: In IDLE with any req_i high, the arbiter SHALL select the first requester at or after rr_ptr (wrapping N_REQ-1 -> 0), latch its index, address, wen, wdata and be, and enter ISSUE.
REQ-022: In ISSUE, tgt_req_o SHALL be 1 with latched fields; on tgt_gnt_i=1, gnt_o[sel] SHALL pulse for exactly that cycle, rr_ptr SHALL become (sel+1) mod N_REQ, and the FSM SHALL enter WAIT_RESP.
REQ-023: Latched request fields SHALL remain stable while in ISSUE even if the core's inputs change.
REQ-024: In WAIT_RESP, on tgt_r_valid_i=1, r_valid_o[sel] SHALL be 1 in the same cycle, r_rdata_o/r_opc_o SHALL equal tgt_r_rdata_i/tgt_r_opc_i, and the FSM SHALL return to IDLE.
REQ-025: A new arbitration SHALL start no earlier than the cycle after the response; minimum request-to-next-grant spacing SHALL be 3 cycles.
REQ-026: tgt_r_valid_i outside WAIT_RESP SHALL be ignored; tgt_gnt_i outside ISSUE SHALL be ignored.
REQ-027: r_rdata_o SHALL be 0 and r_opc_o 0 in any cycle with no r_valid_o bit set.
REQ-028: A core deasserting req_i while in ISSUE SHALL NOT abort the latched transaction.

Reset
REQ-029: rst_i=1 SHALL asynchronously force IDLE, rr_ptr=0, sel=0, timeout counter=0, latched fields=0.
REQ-030: During and after reset all outputs SHALL be 0; a reset mid-transaction SHALL drop it with no response to the core.

Configuration
REQ-031: Macro HWPE_CFG_ARB_TIMEOUT_EN, when defined, SHALL add a counter cleared on entering WAIT_RESP and incremented each WAIT_RESP cycle without tgt_r_valid_i.
REQ-032: With the macro, reaching TIMEOUT_CYCLES SHALL enter ERR_RESP, which for one cycle drives r_valid_o[sel]=1, r_opc_o=1, r_rdata_o=32'hDEADBEEF (truncated/zero-extended to DATA_WIDTH), then IDLE; a late tgt_r_valid_i SHALL be ignored.
REQ-033: Without the macro, ERR_RESP and the counter SHALL not exist and WAIT_RESP SHALL wait indefinitely.

Verification
REQ-034: Single read: core 2 req, add=0x1020_0400, tgt_gnt_i same cycle, r_valid 1 cycle later, rdata=0xCAFE0001 -> gnt_o=4'b0100 once, r_valid_o=4'b0100, r_rdata_o=0xCAFE0001, rr_ptr=3.
REQ-035: Fairness: all 4 cores req continuously from reset -> grant order 0,1,2,3,0 with one response between grants.
REQ-036: Target stall: tgt_gnt_i low 5 cycles while core 1 changes wdata -> target sees original wdata stable, gnt_o[1] only on the grant cycle.
REQ-037: Error passthrough: tgt_r_opc_i=1 on response to core 0 write -> r_valid_o[0]=1, r_opc_o=1.
REQ-038: Reset mid-WAIT_RESP for core 3 -> all outputs 0, next request from core 3 granted with rr_ptr starting at 0.
REQ-039: With HWPE_CFG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no target response -> r_valid_o[sel]=1, r_opc_o=1, r_rdata_o=0xDEADBEEF 8 cycles after grant; late tgt_r_valid_i ignored.

Source files
------------

// File: rtl/hwpe_cfg_arbiter.sv
// Round-robin arbiter sharing one HWPE configuration port among N_REQ cores, one transaction in flight.
// Optional response timeout enabled by defining HWPE_CFG_ARB_TIMEOUT_EN.
module hwpe_cfg_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]     add_i,
  input  logic [N_REQ-1:0]                wen_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]     wdata_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]   be_i,
  output logic [N_REQ-1:0]                gnt_o,
  output logic [N_REQ-1:0]                r_valid_o,
  output logic [DATA_WIDTH-1:0]           r_rdata_o,
  output logic                            r_opc_o,
  output logic                            tgt_req_o,
  output logic [ADDR_WIDTH-1:0]           tgt_add_o,
  output logic                            tgt_wen_o,
  output logic [DATA_WIDTH-1:0]           tgt_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         tgt_be_o,
  input  logic                            tgt_gnt_i,
  input  logic                            tgt_r_valid_i,
  input  logic [DATA_WIDTH-1:0]           tgt_r_rdata_i,
  input  logic                            tgt_r_opc_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(N_REQ);

`ifdef HWPE_CFG_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, ERR_RESP} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hDEADBEEF);
  logic [CNT_W-1:0] to_cnt;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
`endif

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   sel;
  logic [ADDR_WIDTH-1:0] lat_add;
  logic               lat_wen;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_W-1:0]    lat_be;

  logic [IDX_W-1:0]   pick;
  logic [IDX_W:0]     cand;
  logic               found;
  logic [N_REQ-1:0]   sel_oh;

  // First requester at or after rr_ptr, wrapping past the last core.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      lat_add   <= '0;
      lat_wen   <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= '0;
`ifdef HWPE_CFG_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            sel       <= pick;
            lat_add   <= add_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wen   <= wen_i[pick];
            lat_wdata <= wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            lat_be    <= be_i[int'(pick)*BE_W +: BE_W];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (tgt_gnt_i) begin
            rr_ptr <= (sel == IDX_W'(N_REQ-1)) ? '0 : sel + 1'b1;
            state  <= WAIT_RESP;
`ifdef HWPE_CFG_ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        WAIT_RESP: begin
          if (tgt_r_valid_i) begin
            state <= IDLE;
`ifdef HWPE_CFG_ARB_TIMEOUT_EN
          end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            state <= ERR_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_oh      = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
  assign tgt_req_o   = (state == ISSUE);
  assign tgt_add_o   = lat_add;
  assign tgt_wen_o   = lat_wen;
  assign tgt_wdata_o = lat_wdata;
  assign tgt_be_o    = lat_be;

  // Grant and response are same-cycle passthroughs of the target handshake.
  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    r_rdata_o = '0;
    r_opc_o   = 1'b0;
    case (state)
      ISSUE: if (tgt_gnt_i) gnt_o = sel_oh;
      WAIT_RESP: begin
        if (tgt_r_valid_i) begin
          r_valid_o = sel_oh;
          r_rdata_o = tgt_r_rdata_i;
          r_opc_o   = tgt_r_opc_i;
        end
      end
`ifdef HWPE_CFG_ARB_TIMEOUT_EN
      ERR_RESP: begin
        r_valid_o = sel_oh;
        r_rdata_o = ERR_RDATA;
        r_opc_o   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hwpe_cfg_arbiter.sv
// Randomized and directed bench for hwpe_cfg_arbiter against a transaction-level reference model.
module tb_hwpe_cfg_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, wen_i, gnt_o, r_valid_o;
  logic [N*AW-1:0] add_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*BW-1:0] be_i;
  logic [DW-1:0]   r_rdata_o, tgt_wdata_o, tgt_r_rdata_i;
  logic            r_opc_o, tgt_req_o, tgt_wen_o, tgt_gnt_i, tgt_r_valid_i, tgt_r_opc_i;
  logic [AW-1:0]   tgt_add_o;
  logic [BW-1:0]   tgt_be_o;

  hwpe_cfg_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .tgt_req_o(tgt_req_o),
    .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o), .tgt_wdata_o(tgt_wdata_o),
    .tgt_be_o(tgt_be_o), .tgt_gnt_i(tgt_gnt_i), .tgt_r_valid_i(tgt_r_valid_i),
    .tgt_r_rdata_i(tgt_r_rdata_i), .tgt_r_opc_i(tgt_r_opc_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: where the single in-flight transaction is, whose it is, and what was captured.
  int          m_phase = 0;  // 0 none, 1 offered to target, 2 awaiting response, 3 timed out
  int          m_ptr = 0, m_sel = 0, m_wcnt = 0;
  logic [AW-1:0] m_add;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;

  // Observed DUT events, used by the directed checks.
  logic [N-1:0]  gvec[$];
  logic [DW-1:0] gwd[$];
  logic [N-1:0]  rvec[$];
  logic [DW-1:0] rdat[$];
  logic          ropc[$];

  task automatic model_step();
    logic [N-1:0]  e_gnt, e_rv;
    logic [DW-1:0] e_rd;
    logic          e_opc, e_treq;
    e_gnt = '0; e_rv = '0; e_rd = '0; e_opc = 1'b0; e_treq = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_sel = 0; m_wcnt = 0;
      chk("rst_outputs", {gnt_o, r_valid_o, r_rdata_o, r_opc_o, tgt_req_o, tgt_add_o,
                          tgt_wen_o, tgt_wdata_o, tgt_be_o}, '0);
      return;
    end
    case (m_phase)
      0: if (req_i != '0) begin
        for (int i = 0; i < N; i++) begin
          if (req_i[(m_ptr + i) % N]) begin
            m_sel = (m_ptr + i) % N;
            break;
          end
        end
        m_add   = add_i[m_sel*AW +: AW];
        m_wen   = wen_i[m_sel];
        m_wdata = wdata_i[m_sel*DW +: DW];
        m_be    = be_i[m_sel*BW +: BW];
        m_phase = 1;
      end
      1: begin
        e_treq = 1'b1;
        chk("tgt_add", tgt_add_o, m_add);
        chk("tgt_wen", tgt_wen_o, m_wen);
        chk("tgt_wdata", tgt_wdata_o, m_wdata);
        chk("tgt_be", tgt_be_o, m_be);
        if (tgt_gnt_i) begin
          e_gnt[m_sel] = 1'b1;
          m_ptr   = (m_sel + 1) % N;
          m_wcnt  = 0;
          m_phase = 2;
        end
      end
      2: begin
        if (tgt_r_valid_i) begin
          e_rv[m_sel] = 1'b1;
          e_rd  = tgt_r_rdata_i;
          e_opc = tgt_r_opc_i;
          m_phase = 0;
        end
`ifdef HWPE_CFG_ARB_TIMEOUT_EN
        else if (m_wcnt + 1 == TO) m_phase = 3;
        else m_wcnt++;
`endif
      end
      default: begin
        e_rv[m_sel] = 1'b1;
        e_rd  = DW'(32'hDEADBEEF);
        e_opc = 1'b1;
        m_phase = 0;
      end
    endcase
    chk("gnt_o", gnt_o, e_gnt);
    chk("r_valid_o", r_valid_o, e_rv);
    chk("r_rdata_o", r_rdata_o, e_rd);
    chk("r_opc_o", r_opc_o, e_opc);
    chk("tgt_req_o", tgt_req_o, e_treq);
    if (gnt_o != '0) begin gvec.push_back(gnt_o); gwd.push_back(tgt_wdata_o); end
    if (r_valid_o != '0) begin rvec.push_back(r_valid_o); rdat.push_back(r_rdata_o); ropc.push_back(r_opc_o); end
  endtask

  always @(negedge clk) model_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string tag);
    int n0;
    n0 = gvec.size();
    for (int i = 0; i < 50 && gvec.size() == n0; i++) tick();
    chk(tag, gvec.size(), n0 + 1);
  endtask

  task automatic wait_rsp(input string tag);
    int n0;
    n0 = rvec.size();
    for (int i = 0; i < 300 && rvec.size() == n0; i++) tick();
    chk(tag, rvec.size(), n0 + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0;
    rst = 1'b1; req_i = '0; wen_i = '0; add_i = '0; wdata_i = '0; be_i = '0;
    tgt_gnt_i = 1'b0; tgt_r_valid_i = 1'b0; tgt_r_rdata_i = '0; tgt_r_opc_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Single read from core 2.
    tgt_gnt_i = 1'b1; tgt_r_valid_i = 1'b1; tgt_r_rdata_i = 32'hCAFE0001;
    req_i = 4'b0100; wen_i = 4'b0100; add_i[2*AW +: AW] = 32'h1020_0400; be_i = '1;
    g0 = gvec.size();
    wait_gnt("read_gnt_timeout");
    req_i = '0;
    wait_rsp("read_rsp_timeout");
    chk("read_gnt_count", gvec.size(), g0 + 1);
    chk("read_gnt_vec", gvec[$], 4'b0100);
    chk("read_rvalid_vec", rvec[$], 4'b0100);
    chk("read_rdata", rdat[$], 32'hCAFE0001);

    // Pointer now at 3: with cores 0 and 3 asking, core 3 wins.
    req_i = 4'b1001;
    wait_gnt("ptr_gnt_timeout");
    chk("ptr_after_core2", gvec[$], 4'b1000);
    req_i = '0;
    wait_rsp("ptr_rsp_timeout");

    // Error flag on a core 0 write.
    tgt_r_opc_i = 1'b1; tgt_r_rdata_i = 32'h0;
    req_i = 4'b0001; wen_i = 4'b0000; wdata_i[0 +: DW] = 32'h1234_5678;
    wait_gnt("err_gnt_timeout");
    req_i = '0;
    wait_rsp("err_rsp_timeout");
    chk("err_rvalid_vec", rvec[$], 4'b0001);
    chk("err_opc", ropc[$], 1'b1);
    tgt_r_opc_i = 1'b0;

    // Fairness: all four requesting continuously from reset.
    do_reset();
    g0 = gvec.size(); r0 = rvec.size();
    req_i = 4'b1111;
    for (int i = 0; i < 80 && gvec.size() < g0 + 5; i++) tick();
    chk("fair_count", gvec.size() >= g0 + 5, 1'b1);
    for (int k = 0; k < 5; k++)
      chk($sformatf("fair_order%0d", k), (gvec.size() > g0 + k) ? gvec[g0 + k] : 4'b0, 4'b0001 << (k % 4));
    chk("fair_rsp_between", rvec.size() - r0 >= 4, 1'b1);
    req_i = '0;
    repeat (4) tick();

    // Target stall while core 1 keeps changing its write data.
    tgt_gnt_i = 1'b0;
    g0 = gvec.size();
    req_i = 4'b0010; wen_i = 4'b0000; wdata_i[1*DW +: DW] = 32'h1111_1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      wdata_i[1*DW +: DW] = $urandom;
      tick();
    end
    chk("stall_no_gnt", gvec.size(), g0);
    tgt_gnt_i = 1'b1;
    wait_gnt("stall_gnt_timeout");
    chk("stall_gnt_vec", gvec[$], 4'b0010);
    chk("stall_wdata", gwd[$], 32'h1111_1111);
    req_i = '0;
    wait_rsp("stall_rsp_timeout");

    // Reset while core 3 waits for its response.
    tgt_r_valid_i = 1'b0;
    req_i = 4'b1000;
    wait_gnt("midrst_gnt_timeout");
    req_i = '0;
    tick();
    r0 = rvec.size();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("midrst_no_rsp", rvec.size(), r0);
    tgt_r_valid_i = 1'b1;
    req_i = 4'b1000;
    wait_gnt("midrst_regnt_timeout");
    chk("midrst_regnt_vec", gvec[$], 4'b1000);
    req_i = '0;
    wait_rsp("midrst_rsp_timeout");

`ifdef HWPE_CFG_ARB_TIMEOUT_EN
    // Silent target: the arbiter answers with an error word, late response ignored.
    tgt_r_valid_i = 1'b0;
    req_i = 4'b0100;
    wait_gnt("to_gnt_timeout");
    req_i = '0;
    wait_rsp("to_rsp_timeout");
    chk("to_rvalid_vec", rvec[$], 4'b0100);
    chk("to_opc", ropc[$], 1'b1);
    chk("to_rdata", rdat[$], 32'hDEADBEEF);
    r0 = rvec.size();
    tgt_r_valid_i = 1'b1;
    repeat (3) tick();
    chk("to_late_ignored", rvec.size(), r0);
`endif

    // Random traffic, including stray handshakes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      req_i   = N'($urandom);
      wen_i   = N'($urandom);
      be_i    = (N*BW)'($urandom);
      for (int k = 0; k < N; k++) begin
        add_i[k*AW +: AW]   = $urandom;
        wdata_i[k*DW +: DW] = $urandom;
      end
      tgt_gnt_i     = ($urandom_range(0, 2) != 0);
      tgt_r_valid_i = ($urandom_range(0, 3) == 0);
      tgt_r_rdata_i = $urandom;
      tgt_r_opc_i   = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    req_i = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
